adder_result_accumulator: RTL and testbench

Downstream consumer of the pipelined 16-bit adder. Captures each {cout, sum} result as it leaves the adder pipeline and accumulates BLOCK_LEN results into a wider total. The completed total is presented on a valid/ready output port. An internal valid delay line aligns the operand-side valid with the adder's fixed pipeline latency.

---
 rtl/adder_pkg.sv | 19 +
 rtl/adder_result_accumulator_valid_delay_line.sv | 36 +++
 rtl/adder_result_accumulator.sv | 125 ++++++++++++
 tb/tb_adder_result_accumulator.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// +------------------------------------------------------------------+
// | adder_pkg: constants shared by the adder pipeline and consumers  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package adder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int COUNT_W       = 8;
  localparam int STATE_W       = 2;

  localparam logic [STATE_W-1:0] IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ACCUM = 2'd1;
  localparam logic [STATE_W-1:0] DONE  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/adder_result_accumulator_valid_delay_line.sv
// +------------------------------------------------------------------+
// | valid_delay_line: LATENCY-stage valid shift register             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module valid_delay_line #(
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [LATENCY-1:0] r_stage;

  generate
    if (LATENCY == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (reset) r_stage <= '0;
        else       r_stage <= d;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (reset) r_stage <= '0;
        else       r_stage <= {r_stage[LATENCY-2:0], d};
      end
    end
  endgenerate

  assign q = r_stage[LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/adder_result_accumulator.sv
// +------------------------------------------------------------------+
// | adder_result_accumulator: sums BLOCK_LEN adder results per block |
// | Optional macro ACC_SATURATE_EN clamps the total and adds 'sat'.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module adder_result_accumulator
  import adder_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ACC_WIDTH = 24,
  parameter int LATENCY   = 2,
  parameter int BLOCK_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     sum,
  input  logic                 cout,
  input  logic                 start,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [COUNT_W-1:0]   out_count,
  output logic                 busy,
  output logic                 dropped
`ifdef ACC_SATURATE_EN
  ,
  output logic                 sat
`endif
);

  localparam logic [COUNT_W-1:0] c_block_len = COUNT_W'(BLOCK_LEN);

  logic [STATE_W-1:0]   r_state;
  logic [STATE_W-1:0]   w_next;
  logic                 w_rvalid;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic [ACC_WIDTH-1:0] w_value;
  logic [ACC_WIDTH-1:0] r_out_data;
  logic [COUNT_W-1:0]   r_count;
  logic                 r_dropped;
  logic                 w_enter;
  logic                 w_accept;
  logic                 w_last;

  valid_delay_line #(
    .LATENCY(LATENCY)
  ) u_vdl (
    .clk  (clk),
    .reset(reset),
    .d    (in_valid),
    .q    (w_rvalid)
  );

  assign w_value  = ACC_WIDTH'({cout, sum});
  assign w_enter  = (r_state == IDLE) && start;
  assign w_accept = (r_state == ACCUM) && w_rvalid;
  assign w_last   = w_accept && ((r_count + 1'b1) == c_block_len);

`ifdef ACC_SATURATE_EN
  logic [ACC_WIDTH:0] w_sum_ext;
  logic               r_sat;
  assign w_sum_ext  = {1'b0, r_acc} + {1'b0, w_value};
  assign w_acc_next = w_sum_ext[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_sum_ext[ACC_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset)                            r_sat <= 1'b0;
    else if (w_enter)                     r_sat <= 1'b0;
    else if (w_accept && w_sum_ext[ACC_WIDTH]) r_sat <= 1'b1;
  end
  assign sat = r_sat;
`else
  assign w_acc_next = r_acc + w_value;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = ACCUM;
      ACCUM:   if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (r_state == DONE);
    busy      = (r_state == ACCUM) || (r_state == DONE);
  end

  // A result seen outside ACCUM (including the start cycle) is lost, not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc      <= '0;
      r_count    <= '0;
      r_out_data <= '0;
      r_dropped  <= 1'b0;
    end else begin
      if (w_rvalid && (r_state != ACCUM)) r_dropped <= 1'b1;
      if (w_enter) begin
        r_acc   <= '0;
        r_count <= '0;
      end else if (w_accept) begin
        r_acc   <= w_acc_next;
        r_count <= r_count + 1'b1;
        if (w_last) r_out_data <= w_acc_next;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_count = r_count;
  assign dropped   = r_dropped;

endmodule

`default_nettype wire

// File: tb/tb_adder_result_accumulator.sv
// Bench for adder_result_accumulator: behavioural 2-stage adder feeding
// the DUT, table-driven blocks plus directed corner-case sequences.
`default_nettype none

module tb_adder_result_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] sum;
  logic        cout;
  logic        start;
  logic        out_ready;
  logic        out_valid;
  logic [23:0] out_data;
  logic [7:0]  out_count;
  logic        busy;
  logic        dropped;
`ifdef ACC_SATURATE_EN
  logic        sat;
`endif

  logic [15:0] a, b;
  logic        cin;
  logic [16:0] p1, p2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
  } op_t;

  op_t         ops[20];
  int unsigned blk_exp[5];

  always #5 clk = ~clk;

  // Reference adder pipeline with a fixed 2-cycle latency.
  always @(posedge clk) begin
    p1 <= {1'b0, a} + {1'b0, b} + {16'd0, cin};
    p2 <= p1;
  end
  assign {cout, sum} = p2;

  adder_result_accumulator dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .sum      (sum),
    .cout     (cout),
    .start    (start),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_count(out_count),
    .busy     (busy),
    .dropped  (dropped)
`ifdef ACC_SATURATE_EN
    ,
    .sat      (sat)
`endif
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic apply_ops(input int blk, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a        = ops[4*blk+i].a;
      b        = ops[4*blk+i].b;
      cin      = ops[4*blk+i].cin;
      in_valid = 1'b1;
    end
  endtask

  // Final result is on sum two cycles after the last in_valid; out_valid one later.
  task automatic wait_out(input int blk);
    int lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    check($sformatf("blk%0d_latency", blk), lat, 3);
    check($sformatf("blk%0d_data", blk), out_data, blk_exp[blk]);
    check($sformatf("blk%0d_count", blk), out_count, 4);
    check($sformatf("blk%0d_busy", blk), busy, 1);
  endtask

  task automatic handshake(input int blk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("blk%0d_valid_drop", blk), out_valid, 0);
    check($sformatf("blk%0d_idle", blk), busy, 0);
  endtask

  initial begin
    ops[0]  = '{16'd29, 16'd85, 1'b0};
    ops[1]  = '{16'd105, 16'd15, 1'b0};
    ops[2]  = '{16'd121, 16'd15, 1'b0};
    ops[3]  = '{16'd233, 16'd527, 1'b0};
    blk_exp[0] = 1130;
    for (int i = 4; i < 8; i++) ops[i] = '{16'hFFFF, 16'h0001, 1'b0};
    blk_exp[1] = 262144;
    ops[8]  = '{16'd100, 16'd200, 1'b1};
    ops[9]  = '{16'd0, 16'd0, 1'b0};
    ops[10] = '{16'hFFFF, 16'hFFFF, 1'b1};
    ops[11] = '{16'd10, 16'd20, 1'b0};
    blk_exp[2] = 131402;
    for (int i = 12; i < 16; i++) ops[i] = '{16'hFFFF, 16'hFFFF, 1'b1};
    blk_exp[3] = 524284;
    for (int i = 16; i < 20; i++) ops[i] = '{16'd1, 16'd1, 1'b0};
    blk_exp[4] = 8;

    reset = 1'b1; in_valid = 1'b0; start = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_count", out_count, 0);
    check("rst_busy", busy, 0);
    check("rst_dropped", dropped, 0);

    for (int blk = 0; blk < 4; blk++) begin
      pulse_start();
      apply_ops(blk, 4);
      wait_out(blk);
      if (blk == 0) begin
        for (int c = 0; c < 5; c++) begin
          start = (c == 2);
          @(negedge clk);
          check($sformatf("bp%0d_valid", c), out_valid, 1);
          check($sformatf("bp%0d_data", c), out_data, 1130);
        end
        start = 1'b0;
        check("bp_count_held", out_count, 4);
      end
      handshake(blk);
    end
    check("no_drop_yet", dropped, 0);

    // Result arriving in IDLE is dropped.
    @(negedge clk);
    a = 16'd7; b = 16'd8; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("drop_flag", dropped, 1);
    check("drop_count", out_count, 4);
    check("drop_idle", busy, 0);

    // Reset mid-block with results in flight.
    pulse_start();
    apply_ops(4, 3);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_count2", out_count, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_count", out_count, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dropped", dropped, 0);
    @(negedge clk);
    check("mid_inflight_lost", out_count, 0);

    // start coincides with an rvalid in IDLE: enter ACCUM, result not counted.
    a = 16'd50; b = 16'd50; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("coinc_busy", busy, 1);
    check("coinc_count", out_count, 0);
    check("coinc_dropped", dropped, 1);
    apply_ops(4, 4);
    wait_out(4);
    handshake(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
